// File: rtl/id_issue_stage_pkg.sv
// Shared types and defaults for the decode/issue stage and its scoreboard.
package id_issue_stage_pkg;

   localparam int ISSUE_ADD_WIDTH  = 5;
   localparam int ISSUE_NUM_REG    = 32;
   localparam int ISSUE_CTRL_WIDTH = 32;

   typedef struct packed {
      logic [31:0]                  pc;
      logic [ISSUE_ADD_WIDTH-1:0]   rd_add;
      logic                         rd_wr;
      logic                         long;
      logic [ISSUE_CTRL_WIDTH-1:0]  ctrl;
   } issue_bundle_t;

   typedef enum logic [1:0] {
      STALL_NONE,
      STALL_SB,
      STALL_OUT_LONG,
      STALL_DOWNSTREAM
   } stall_reason_e;

endpackage

// File: rtl/id_issue_stage_if.sv
// Decoder-side and EX-side handshake bundle of the issue stage.
// The stage connects through the slave modport; its environment uses master.
interface id_issue_stage_if
   import id_issue_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADD_WIDTH  = ISSUE_ADD_WIDTH,
   parameter int NUM_RS     = 2,
   parameter int CTRL_WIDTH = ISSUE_CTRL_WIDTH
) ();

   logic                         in_valid;
   logic                         in_ready;
   logic [31:0]                  in_pc;
   logic [NUM_RS*ADD_WIDTH-1:0]  in_rs_add;
   logic [NUM_RS-1:0]            in_rs_used;
   logic [ADD_WIDTH-1:0]         in_rd_add;
   logic                         in_rd_wr;
   logic                         in_long;
   logic [CTRL_WIDTH-1:0]        in_ctrl;

   logic                         out_valid;
   logic                         out_ready;
   logic [31:0]                  out_pc;
   logic [NUM_RS*ADD_WIDTH-1:0]  out_rs_add;
   logic [NUM_RS*DATA_WIDTH-1:0] out_rs_data;
   logic [ADD_WIDTH-1:0]         out_rd_add;
   logic                         out_rd_wr;
   logic                         out_long;
   logic [CTRL_WIDTH-1:0]        out_ctrl;

   modport slave (
      input  in_valid, in_pc, in_rs_add, in_rs_used, in_rd_add, in_rd_wr, in_long, in_ctrl,
      input  out_ready,
      output in_ready,
      output out_valid, out_pc, out_rs_add, out_rs_data, out_rd_add, out_rd_wr, out_long, out_ctrl
   );

   modport master (
      output in_valid, in_pc, in_rs_add, in_rs_used, in_rd_add, in_rd_wr, in_long, in_ctrl,
      output out_ready,
      input  in_ready,
      input  out_valid, out_pc, out_rs_add, out_rs_data, out_rd_add, out_rd_wr, out_long, out_ctrl
   );

endinterface

// File: rtl/id_scoreboard.sv
// Pending-writeback scoreboard for long-latency results, with one query per source port.
// A writeback clearing the queried register this cycle is not reported as a hit.
module id_scoreboard
   import id_issue_stage_pkg::*;
#(
   parameter int NUM_REG   = ISSUE_NUM_REG,
   parameter int ADD_WIDTH = ISSUE_ADD_WIDTH,
   parameter int NUM_RS    = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        set_en,
   input  logic [ADD_WIDTH-1:0]        set_add,
   input  logic                        clr_en,
   input  logic [ADD_WIDTH-1:0]        clr_add,
   input  logic [NUM_RS*ADD_WIDTH-1:0] q_add,
   input  logic [NUM_RS-1:0]           q_used,
   output logic [NUM_RS-1:0]           q_hit,
   output logic                        busy
);

   logic [NUM_REG-1:0] sb_q;
   logic [NUM_REG-1:0] sb_d;

   // Set is applied after clear so a same-register set/clear leaves the bit set.
   always_comb begin
      sb_d = sb_q;
      if (clr_en) sb_d[clr_add] = 1'b0;
      if (set_en) sb_d[set_add] = 1'b1;
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) sb_q <= '0;
      else     sb_q <= sb_d;
   end

   for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_query
      logic [ADD_WIDTH-1:0] add;
      assign add       = q_add[gi*ADD_WIDTH +: ADD_WIDTH];
      assign q_hit[gi] = q_used[gi] && (add != '0) && sb_q[add] && !(clr_en && (clr_add == add));
   end

   assign busy = |sb_q;

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: register file, WB bypass, load-use scoreboard, one output register to EX.
// Optional stall counter output perf_stall_cnt is built when ID_ISSUE_PERF_EN is defined.
module id_issue_stage
   import id_issue_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REG    = ISSUE_NUM_REG,
   parameter int ADD_WIDTH  = ISSUE_ADD_WIDTH,
   parameter int NUM_RS     = 2,
   parameter int CTRL_WIDTH = ISSUE_CTRL_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   id_issue_stage_if.slave       bus,
   input  logic                  wb_valid,
   input  logic [ADD_WIDTH-1:0]  wb_rd_add,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  sb_busy
`ifdef ID_ISSUE_PERF_EN
   ,
   output logic [31:0]           perf_stall_cnt
`endif
);

   logic [DATA_WIDTH-1:0]        rf_q [NUM_REG];
   logic [DATA_WIDTH-1:0]        rf_d [NUM_REG];

   logic                         out_valid_q,   out_valid_d;
   logic [31:0]                  out_pc_q,      out_pc_d;
   logic [NUM_RS*ADD_WIDTH-1:0]  out_rs_add_q,  out_rs_add_d;
   logic [NUM_RS*DATA_WIDTH-1:0] out_rs_data_q, out_rs_data_d;
   logic [ADD_WIDTH-1:0]         out_rd_add_q,  out_rd_add_d;
   logic                         out_rd_wr_q,   out_rd_wr_d;
   logic                         out_long_q,    out_long_d;
   logic [CTRL_WIDTH-1:0]        out_ctrl_q,    out_ctrl_d;

   logic [ADD_WIDTH-1:0]         rs_add   [NUM_RS];
   logic [ADD_WIDTH-1:0]         held_add [NUM_RS];
   logic [DATA_WIDTH-1:0]        rd_val   [NUM_RS];
   logic [NUM_RS-1:0]            long_hit;
   logic [NUM_RS-1:0]            sb_hit;
   stall_reason_e                stall_reason;
   logic                         in_ready;
   logic                         accept;
   logic                         hold;
   logic                         wb_wr;
   logic                         sb_set;

   assign wb_wr = wb_valid && (wb_rd_add != '0);

   always_comb begin
      rf_d = rf_q;
      if (wb_wr) rf_d[wb_rd_add] = wb_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REG; i++) rf_q[i] <= '0;
      end else begin
         rf_q <= rf_d;
      end
   end

   for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_port
      assign rs_add[gi]   = bus.in_rs_add[gi*ADD_WIDTH +: ADD_WIDTH];
      assign held_add[gi] = out_rs_add_q[gi*ADD_WIDTH +: ADD_WIDTH];
      assign rd_val[gi]   = (rs_add[gi] == '0)                      ? '0      :
                            (wb_valid && (wb_rd_add == rs_add[gi])) ? wb_data :
                                                                      rf_q[rs_add[gi]];
      // The instruction in the output register has not issued yet, so the scoreboard cannot see it.
      assign long_hit[gi] = bus.in_rs_used[gi] && (rs_add[gi] != '0) && out_valid_q &&
                            out_long_q && out_rd_wr_q && (out_rd_add_q == rs_add[gi]);
   end

   assign sb_set = out_valid_q && bus.out_ready && !flush && out_long_q && out_rd_wr_q &&
                   (out_rd_add_q != '0);

   id_scoreboard #(
      .NUM_REG   (NUM_REG),
      .ADD_WIDTH (ADD_WIDTH),
      .NUM_RS    (NUM_RS)
   ) u_scoreboard (
      .clk     (clk),
      .rst     (rst),
      .set_en  (sb_set),
      .set_add (out_rd_add_q),
      .clr_en  (wb_valid),
      .clr_add (wb_rd_add),
      .q_add   (bus.in_rs_add),
      .q_used  (bus.in_rs_used),
      .q_hit   (sb_hit),
      .busy    (sb_busy)
   );

   always_comb begin
      stall_reason = STALL_NONE;
      if (|sb_hit)                             stall_reason = STALL_SB;
      else if (|long_hit)                      stall_reason = STALL_OUT_LONG;
      else if (out_valid_q && !bus.out_ready)  stall_reason = STALL_DOWNSTREAM;
   end

   assign in_ready = !flush && (stall_reason == STALL_NONE);
   assign accept   = bus.in_valid && in_ready;
   assign hold     = out_valid_q && !bus.out_ready;

   always_comb begin
      out_valid_d   = out_valid_q;
      out_pc_d      = out_pc_q;
      out_rs_add_d  = out_rs_add_q;
      out_rs_data_d = out_rs_data_q;
      out_rd_add_d  = out_rd_add_q;
      out_rd_wr_d   = out_rd_wr_q;
      out_long_d    = out_long_q;
      out_ctrl_d    = out_ctrl_q;
      if (accept) begin
         out_valid_d  = 1'b1;
         out_pc_d     = bus.in_pc;
         out_rs_add_d = bus.in_rs_add;
         out_rd_add_d = bus.in_rd_add;
         out_rd_wr_d  = bus.in_rd_wr;
         out_long_d   = bus.in_long;
         out_ctrl_d   = bus.in_ctrl;
         for (int i = 0; i < NUM_RS; i++) out_rs_data_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_val[i];
      end else begin
         if (bus.out_ready || flush) out_valid_d = 1'b0;
         // Keep stalled operands coherent with writebacks that land while EX is busy.
         if (hold) begin
            for (int i = 0; i < NUM_RS; i++) begin
               if (wb_valid && (held_add[i] != '0) && (wb_rd_add == held_add[i]))
                  out_rs_data_d[i*DATA_WIDTH +: DATA_WIDTH] = wb_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_pc_q      <= '0;
         out_rs_add_q  <= '0;
         out_rs_data_q <= '0;
         out_rd_add_q  <= '0;
         out_rd_wr_q   <= 1'b0;
         out_long_q    <= 1'b0;
         out_ctrl_q    <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_pc_q      <= out_pc_d;
         out_rs_add_q  <= out_rs_add_d;
         out_rs_data_q <= out_rs_data_d;
         out_rd_add_q  <= out_rd_add_d;
         out_rd_wr_q   <= out_rd_wr_d;
         out_long_q    <= out_long_d;
         out_ctrl_q    <= out_ctrl_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_pc      = out_pc_q;
   assign bus.out_rs_add  = out_rs_add_q;
   assign bus.out_rs_data = out_rs_data_q;
   assign bus.out_rd_add  = out_rd_add_q;
   assign bus.out_rd_wr   = out_rd_wr_q;
   assign bus.out_long    = out_long_q;
   assign bus.out_ctrl    = out_ctrl_q;

`ifdef ID_ISSUE_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (bus.in_valid && !in_ready && !flush && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) perf_q <= '0;
      else     perf_q <= perf_d;
   end

   assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed testbench for id_issue_stage: bypass, load-use stall, held refresh, flush, x0, reset.
module tb_id_issue_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NRS = 2;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          wb_valid;
   logic [AW-1:0] wb_rd_add;
   logic [DW-1:0] wb_data;
   logic          sb_busy;
`ifdef ID_ISSUE_PERF_EN
   logic [31:0]   perf_stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   id_issue_stage_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .NUM_RS(NRS), .CTRL_WIDTH(CW)) bus ();

   id_issue_stage #(.DATA_WIDTH(DW), .NUM_REG(32), .ADD_WIDTH(AW), .NUM_RS(NRS), .CTRL_WIDTH(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus),
      .wb_valid  (wb_valid),
      .wb_rd_add (wb_rd_add),
      .wb_data   (wb_data),
      .sb_busy   (sb_busy)
`ifdef ID_ISSUE_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.in_valid   = 1'b0;
      bus.in_pc      = '0;
      bus.in_rs_add  = '0;
      bus.in_rs_used = '0;
      bus.in_rd_add  = '0;
      bus.in_rd_wr   = 1'b0;
      bus.in_long    = 1'b0;
      bus.in_ctrl    = '0;
      wb_valid       = 1'b0;
      wb_rd_add      = '0;
      wb_data        = '0;
      flush          = 1'b0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [1:0] used, input logic [AW-1:0] rd, input logic rd_wr,
                        input logic lng, input logic [31:0] ctrl);
      bus.in_valid   = 1'b1;
      bus.in_pc      = pc;
      bus.in_rs_add  = {rs2, rs1};
      bus.in_rs_used = used;
      bus.in_rd_add  = rd;
      bus.in_rd_wr   = rd_wr;
      bus.in_long    = lng;
      bus.in_ctrl    = ctrl;
   endtask

   task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wb_valid  = 1'b1;
      wb_rd_add = a;
      wb_data   = d;
   endtask

   task automatic test_reset();
      idle();
      bus.out_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); end
      checks++; if (bus.out_rs_data !== 64'h0) begin errors++; $display("FAIL reset_out_rs_data: got %h want 0", bus.out_rs_data); end
      checks++; if (bus.out_ctrl !== 32'h0) begin errors++; $display("FAIL reset_out_ctrl: got %h want 0", bus.out_ctrl); end
      checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL reset_sb_busy: got %b want 0", sb_busy); end
      settle();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_bypass();
      idle();
      drive(32'h100, 5'd5, 5'd6, 2'b11, 5'd1, 1'b1, 1'b0, 32'hA5A5);
      wb(5'd5, 32'hDEADBEEF);
      settle();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bypass_in_ready: got %b want 1", bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bypass_out_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_rs_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs0: got %h want deadbeef", bus.out_rs_data[31:0]); end
      checks++; if (bus.out_rs_data[63:32] !== 32'h0) begin errors++; $display("FAIL bypass_rs1: got %h want 0", bus.out_rs_data[63:32]); end
      checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL bypass_pc: got %h want 100", bus.out_pc); end
      checks++; if (bus.out_ctrl !== 32'hA5A5) begin errors++; $display("FAIL bypass_ctrl: got %h want a5a5", bus.out_ctrl); end
      checks++; if (bus.out_rd_add !== 5'd1) begin errors++; $display("FAIL bypass_rd_add: got %0d want 1", bus.out_rd_add); end
      idle();
      drive(32'h104, 5'd5, 5'd0, 2'b01, 5'd2, 1'b1, 1'b0, 32'h0);
      tick();
      checks++; if (bus.out_rs_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_read_x5: got %h want deadbeef", bus.out_rs_data[31:0]); end
      idle();
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bypass_drain: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_load_use();
      idle();
      drive(32'h200, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 32'h0);
      tick();
      idle();
      drive(32'h204, 5'd0, 5'd7, 2'b10, 5'd8, 1'b1, 1'b0, 32'h0);
      settle();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_outlong: got %b want 0", bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lu_issued_valid: got %b want 0", bus.out_valid); end
      checks++; if (sb_busy !== 1'b1) begin errors++; $display("FAIL lu_sb_set: got %b want 1", sb_busy); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_sb: got %b want 0", bus.in_ready); end
      tick();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_sb2: got %b want 0", bus.in_ready); end
      wb(5'd7, 32'h12345678);
      settle();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lu_wb_release: got %b want 1", bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lu_accept_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_rs_data[63:32] !== 32'h12345678) begin errors++; $display("FAIL lu_operand: got %h want 12345678", bus.out_rs_data[63:32]); end
      checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL lu_sb_clear: got %b want 0", sb_busy); end
      idle();
      tick();
   endtask

   task automatic test_hold_refresh();
      idle();
      bus.out_ready = 1'b0;
      wb(5'd3, 32'h11);
      tick();
      idle();
      drive(32'h300, 5'd3, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 32'h0);
      tick();
      checks++; if (bus.out_rs_data[31:0] !== 32'h11) begin errors++; $display("FAIL hold_initial: got %h want 11", bus.out_rs_data[31:0]); end
      idle();
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b want 0", bus.in_ready); end
      wb(5'd3, 32'h22);
      tick();
      checks++; if (bus.out_rs_data[31:0] !== 32'h22) begin errors++; $display("FAIL hold_refresh: got %h want 22", bus.out_rs_data[31:0]); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_refresh_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_pc !== 32'h300) begin errors++; $display("FAIL hold_pc: got %h want 300", bus.out_pc); end
      idle();
      bus.out_ready = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_flush_issue();
      idle();
      drive(32'h400, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 32'h0);
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b want 1", bus.out_valid); end
      idle();
      drive(32'h404, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0, 1'b0, 32'h0);
      flush = 1'b1;
      settle();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL flush_sb: got %b want 0", sb_busy); end
      idle();
      drive(32'h408, 5'd9, 5'd0, 2'b01, 5'd1, 1'b0, 1'b0, 32'h0);
      settle();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_no_stall_x9: got %b want 1", bus.in_ready); end
      idle();
      tick();
   endtask

   task automatic test_x0();
      idle();
      drive(32'h500, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 32'h0);
      tick();
      idle();
      drive(32'h504, 5'd0, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0, 32'h0);
      settle();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL x0_no_stall: got %b want 1", bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL x0_accept: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_rs_data[31:0] !== 32'h0) begin errors++; $display("FAIL x0_operand: got %h want 0", bus.out_rs_data[31:0]); end
      checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL x0_sb: got %b want 0", sb_busy); end
      idle();
      wb(5'd0, 32'hFFFF);
      drive(32'h508, 5'd0, 5'd12, 2'b11, 5'd0, 1'b0, 1'b0, 32'h0);
      tick();
      checks++; if (bus.out_rs_data[31:0] !== 32'h0) begin errors++; $display("FAIL x0_wb_bypass: got %h want 0", bus.out_rs_data[31:0]); end
      checks++; if (bus.out_rs_data[63:32] !== 32'h0) begin errors++; $display("FAIL x12_unwritten: got %h want 0", bus.out_rs_data[63:32]); end
      idle();
      drive(32'h50C, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 32'h0);
      tick();
      checks++; if (bus.out_rs_data[31:0] !== 32'h0) begin errors++; $display("FAIL x0_after_wb: got %h want 0", bus.out_rs_data[31:0]); end
      idle();
      tick();
   endtask

   task automatic test_back_to_back();
      idle();
      for (int k = 0; k < 3; k++) begin
         drive(32'h600 + 32'(4 * k), 5'd0, 5'd0, 2'b00, 5'(k + 1), 1'b1, 1'b0, 32'(k));
         tick();
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d: got %b want 1", k, bus.out_valid); end
         checks++; if (bus.out_pc !== 32'h600 + 32'(4 * k)) begin errors++; $display("FAIL b2b_pc_%0d: got %h want %h", k, bus.out_pc, 32'h600 + 32'(4 * k)); end
      end
      idle();
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_reset_mid_stall();
      idle();
      wb(5'd4, 32'h44);
      tick();
      idle();
      drive(32'h700, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1, 32'h0);
      tick();
      idle();
      tick();
      checks++; if (sb_busy !== 1'b1) begin errors++; $display("FAIL rms_sb_set: got %b want 1", sb_busy); end
      drive(32'h704, 5'd4, 5'd0, 2'b01, 5'd13, 1'b1, 1'b0, 32'h0);
      settle();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rms_stalled: got %b want 0", bus.in_ready); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rms_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL rms_sb_busy: got %b want 0", sb_busy); end
      settle();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rms_in_ready: got %b want 1", bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rms_accept: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_pc !== 32'h704) begin errors++; $display("FAIL rms_pc: got %h want 704", bus.out_pc); end
      checks++; if (bus.out_rs_data[31:0] !== 32'h0) begin errors++; $display("FAIL rms_rf_cleared: got %h want 0", bus.out_rs_data[31:0]); end
      idle();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      bus.out_ready = 1'b1;
      idle();
      test_reset();
      test_bypass();
      test_load_use();
      test_hold_refresh();
      test_flush_issue();
      test_x0();
      test_back_to_back();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
